// File: rtl/tmds_channel_encoder_if.sv
// Symbol bus between the HDMI packet/video mux and one TMDS channel encoder.
//   mode      : symbol type (0=CONTROL 1=VIDEO 2=VIDEO_GUARD 3=DI_GUARD 4=TERC4)
//   vd        : video byte
//   cd        : control bits {c1,c0}
//   td        : TERC4 nibble
//   tmds      : encoded 10-bit symbol, tmds[0] transmitted first
//   disparity : signed running disparity after the current tmds symbol
interface tmds_channel_encoder_if #(
    parameter int DISP_W = 5
);
    logic [2:0]        mode;
    logic [7:0]        vd;
    logic [1:0]        cd;
    logic [3:0]        td;
    logic [9:0]        tmds;
    logic [DISP_W-1:0] disparity;

    modport master (output mode, vd, cd, td, input tmds, disparity);
    modport slave  (input mode, vd, cd, td, output tmds, disparity);
endinterface

// File: rtl/tmds_channel_encoder.sv
// Two-stage TMDS channel encoder: DVI video, control, HDMI video/data-island
// guard bands and TERC4 data-island symbols.
//   clk   : pixel clock
//   rst_n : synchronous active-low reset
//   ce    : clock enable; all state (including disparity) holds when 0
//   bus   : symbol inputs and encoded tmds/disparity outputs
// Stage 1 does transition minimisation and counts ones of q_m; stage 2 does
// DC balancing and symbol selection.
module tmds_channel_encoder #(
    parameter int CHANNEL = 0,
    parameter int DISP_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    tmds_channel_encoder_if.slave bus
);
    typedef enum logic [2:0] {
        M_CTRL   = 3'd0,
        M_VIDEO  = 3'd1,
        M_VGUARD = 3'd2,
        M_DGUARD = 3'd3,
        M_TERC4  = 3'd4
    } mode_e;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] GB_HI   = 10'b1100110010;
    localparam logic [9:0] GB_LO   = 10'b0011001101;

    function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
        case (c)
            2'b00:   ctrl_sym = 10'b1101010100;
            2'b01:   ctrl_sym = 10'b0010101011;
            2'b10:   ctrl_sym = 10'b0101010100;
            default: ctrl_sym = 10'b1010101011;
        endcase
    endfunction

    // Standard TERC4 table, written as tmds[9:0].
    function automatic logic [9:0] terc4(input logic [3:0] d);
        case (d)
            4'h0:    terc4 = 10'b0011100101;
            4'h1:    terc4 = 10'b1100011001;
            4'h2:    terc4 = 10'b0010011101;
            4'h3:    terc4 = 10'b0100011101;
            4'h4:    terc4 = 10'b1000111010;
            4'h5:    terc4 = 10'b0111100010;
            4'h6:    terc4 = 10'b0111000110;
            4'h7:    terc4 = 10'b0011110010;
            4'h8:    terc4 = 10'b0011001101;
            4'h9:    terc4 = 10'b1001110010;
            4'hA:    terc4 = 10'b0011100110;
            4'hB:    terc4 = 10'b0110001101;
            4'hC:    terc4 = 10'b0111000101;
            4'hD:    terc4 = 10'b1000111001;
            4'hE:    terc4 = 10'b1100011010;
            default: terc4 = 10'b1100001101;
        endcase
    endfunction

    // ---------------- stage 1 ----------------
    mode_e       mode_in;
    logic [3:0]  n1_vd;
    logic        use_xnor;
    logic [8:0]  qm;
    logic [3:0]  n1_qm;

    always_comb begin
        mode_in = (bus.mode > 3'd4) ? M_CTRL : mode_e'(bus.mode);
        n1_vd = '0;
        for (int i = 0; i < 8; i++) n1_vd = n1_vd + {3'b000, bus.vd[i]};
        use_xnor = (n1_vd > 4'd4) || ((n1_vd == 4'd4) && !bus.vd[0]);
        qm = '0;
        qm[0] = bus.vd[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xnor ? ~(qm[i-1] ^ bus.vd[i]) : (qm[i-1] ^ bus.vd[i]);
        qm[8] = ~use_xnor;
        n1_qm = '0;
        for (int i = 0; i < 8; i++) n1_qm = n1_qm + {3'b000, qm[i]};
    end

    mode_e      s1_mode;
    logic [1:0] s1_cd;
    logic [3:0] s1_td;
    logic [8:0] s1_qm;
    logic [3:0] s1_n1;
    logic [3:0] s1_n0;

    // ---------------- stage 2 ----------------
    logic [9:0]               sym;
    logic signed [DISP_W-1:0] disp;
    logic [9:0]               sym_nx;
    logic signed [DISP_W-1:0] disp_nx;
    logic signed [DISP_W-1:0] d10;
    logic signed [DISP_W-1:0] two;
    logic                     disp_pos;
    logic                     disp_neg;

    always_comb begin
        sym_nx   = ctrl_sym(s1_cd);
        disp_nx  = '0;
        two      = $signed(DISP_W'(2));
        d10      = $signed({{(DISP_W-4){1'b0}}, s1_n1}) - $signed({{(DISP_W-4){1'b0}}, s1_n0});
        disp_neg = disp[DISP_W-1];
        disp_pos = !disp[DISP_W-1] && (disp != '0);
        case (s1_mode)
            M_VIDEO: begin
                if ((disp == '0) || (s1_n1 == s1_n0)) begin
                    sym_nx  = {~s1_qm[8], s1_qm[8], s1_qm[8] ? s1_qm[7:0] : ~s1_qm[7:0]};
                    disp_nx = s1_qm[8] ? disp + d10 : disp - d10;
                end else if ((disp_pos && (s1_n1 > s1_n0)) || (disp_neg && (s1_n0 > s1_n1))) begin
                    sym_nx  = {1'b1, s1_qm[8], ~s1_qm[7:0]};
                    disp_nx = disp - d10 + (s1_qm[8] ? two : '0);
                end else begin
                    sym_nx  = {1'b0, s1_qm[8], s1_qm[7:0]};
                    disp_nx = disp + d10 - (s1_qm[8] ? '0 : two);
                end
            end
            M_VGUARD: sym_nx = (CHANNEL == 1) ? GB_HI : GB_LO;
            M_DGUARD: sym_nx = (CHANNEL == 0) ? terc4({2'b11, s1_cd}) : GB_HI;
            M_TERC4:  sym_nx = terc4(s1_td);
            default:  sym_nx = ctrl_sym(s1_cd);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_mode <= M_CTRL;
            s1_cd   <= '0;
            s1_td   <= '0;
            s1_qm   <= '0;
            s1_n1   <= '0;
            s1_n0   <= '0;
            sym     <= CTRL_00;
            disp    <= '0;
        end else if (ce) begin
            s1_mode <= mode_in;
            s1_cd   <= bus.cd;
            s1_td   <= bus.td;
            s1_qm   <= qm;
            s1_n1   <= n1_qm;
            s1_n0   <= 4'd8 - n1_qm;
            sym     <= sym_nx;
            disp    <= disp_nx;
        end
    end

    assign bus.tmds      = sym;
    assign bus.disparity = disp;
endmodule

// File: tb/tb_tmds_channel_encoder.sv
module tb_tmds_channel_encoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce = 1'b1;
    logic [2:0] mode = 3'd0;
    logic [7:0] vd = 8'd0;
    logic [1:0] cd = 2'd0;
    logic [3:0] td = 4'd0;

    always #5 clk = ~clk;

    tmds_channel_encoder_if #(.DISP_W(5)) if0 ();
    tmds_channel_encoder_if #(.DISP_W(5)) if1 ();
    tmds_channel_encoder_if #(.DISP_W(5)) if2 ();

    assign if0.mode = mode; assign if0.vd = vd; assign if0.cd = cd; assign if0.td = td;
    assign if1.mode = mode; assign if1.vd = vd; assign if1.cd = cd; assign if1.td = td;
    assign if2.mode = mode; assign if2.vd = vd; assign if2.cd = cd; assign if2.td = td;

    tmds_channel_encoder #(.CHANNEL(0), .DISP_W(5)) u_ch0 (.clk(clk), .rst_n(rst_n), .ce(ce), .bus(if0.slave));
    tmds_channel_encoder #(.CHANNEL(1), .DISP_W(5)) u_ch1 (.clk(clk), .rst_n(rst_n), .ce(ce), .bus(if1.slave));
    tmds_channel_encoder #(.CHANNEL(2), .DISP_W(5)) u_ch2 (.clk(clk), .rst_n(rst_n), .ce(ce), .bus(if2.slave));

    typedef struct {
        logic [2:0][9:0] t;
        int              d;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   mcnt;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [9:0] m_ctrl(input logic [1:0] c);
        logic [9:0] r;
        case (c)
            2'b00:   r = 10'b1101010100;
            2'b01:   r = 10'b0010101011;
            2'b10:   r = 10'b0101010100;
            default: r = 10'b1010101011;
        endcase
        return r;
    endfunction

    function automatic logic [9:0] m_terc4(input logic [3:0] d);
        logic [9:0] t [16];
        t[0]  = 10'b0011100101; t[1]  = 10'b1100011001; t[2]  = 10'b0010011101; t[3]  = 10'b0100011101;
        t[4]  = 10'b1000111010; t[5]  = 10'b0111100010; t[6]  = 10'b0111000110; t[7]  = 10'b0011110010;
        t[8]  = 10'b0011001101; t[9]  = 10'b1001110010; t[10] = 10'b0011100110; t[11] = 10'b0110001101;
        t[12] = 10'b0111000101; t[13] = 10'b1000111001; t[14] = 10'b1100011010; t[15] = 10'b1100001101;
        return t[d];
    endfunction

    // DVI 1.0 video encoder reference; advances mcnt.
    task automatic video_model(input logic [7:0] d, output logic [9:0] s);
        int ones = 0;
        int n1 = 0;
        int n0;
        logic xn;
        logic [8:0] qm;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        xn = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? (qm[i-1] == d[i]) : (qm[i-1] != d[i]);
        qm[8] = !xn;
        for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
        n0 = 8 - n1;
        if (mcnt == 0 || n1 == n0) begin
            s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            mcnt += qm[8] ? (n1 - n0) : (n0 - n1);
        end else if ((mcnt > 0 && n1 > n0) || (mcnt < 0 && n0 > n1)) begin
            s = {1'b1, qm[8], ~qm[7:0]};
            mcnt += 2 * int'(qm[8]) + (n0 - n1);
        end else begin
            s = {1'b0, qm[8], qm[7:0]};
            mcnt += -2 * int'(!qm[8]) + (n1 - n0);
        end
    endtask

    task automatic build_exp(input logic [2:0] m, input logic [7:0] v, input logic [1:0] c,
                             input logic [3:0] t, output exp_t e);
        logic [9:0] s;
        mcnt = (m == 3'd1) ? mcnt : 0;
        case (m)
            3'd1: begin video_model(v, s); e.t = {s, s, s}; end
            3'd2: e.t = {10'b0011001101, 10'b1100110010, 10'b0011001101};
            3'd3: e.t = {10'b1100110010, 10'b1100110010, m_terc4({2'b11, c})};
            3'd4: begin s = m_terc4(t); e.t = {s, s, s}; end
            default: begin s = m_ctrl(c); e.t = {s, s, s}; end
        endcase
        e.d = mcnt;
    endtask

    // One clock: drive inputs, clock, then compare outputs against the scoreboard.
    task automatic step(input logic r, input logic c, input logic [2:0] m, input logic [7:0] v,
                        input logic [1:0] cdv, input logic [3:0] tv, input string tag);
        exp_t e;
        exp_t rs;
        rst_n = r; ce = c; mode = m; vd = v; cd = cdv; td = tv;
        if (r && c) build_exp(m, v, cdv, tv, e);
        @(posedge clk);
        #1;
        if (!r) begin
            rs.t = {3{10'b1101010100}};
            rs.d = 0;
            q.delete();
            mcnt = 0;
            q.push_back(rs);
            last = rs;
        end else if (c) begin
            q.push_back(e);
            last = q.pop_front();
        end
        chk({tag, " ch0 tmds"}, int'(if0.tmds), int'(last.t[0]));
        chk({tag, " ch1 tmds"}, int'(if1.tmds), int'(last.t[1]));
        chk({tag, " ch2 tmds"}, int'(if2.tmds), int'(last.t[2]));
        chk({tag, " ch0 disp"}, int'($signed(if0.disparity)), last.d);
        chk({tag, " ch1 disp"}, int'($signed(if1.disparity)), last.d);
        chk({tag, " ch2 disp"}, int'($signed(if2.disparity)), last.d);
    endtask

    initial begin
        // 1: reset held with video input present, then release
        repeat (3) step(0, 1, 3'd1, 8'hFF, 2'd0, 4'd0, "rst_hold");
        chk("rst code", int'(if0.tmds), int'(10'b1101010100));
        step(1, 1, 3'd1, 8'hFF, 2'd0, 4'd0, "rel1");
        chk("rel1 code", int'(if1.tmds), int'(10'b1101010100));
        step(1, 1, 3'd1, 8'hFF, 2'd0, 4'd0, "rel2");
        chk("ff video", int'(if0.tmds), int'(10'b1000000000));
        chk("ff disp", int'($signed(if0.disparity)), -8);

        // 2: two zero bytes from reset
        step(0, 1, 3'd0, 8'h00, 2'd0, 4'd0, "rst2");
        step(1, 1, 3'd1, 8'h00, 2'd0, 4'd0, "v00a");
        step(1, 1, 3'd1, 8'h00, 2'd0, 4'd0, "v00b");
        chk("v00 first", int'(if2.tmds), int'(10'b0100000000));
        chk("v00 first disp", int'($signed(if2.disparity)), -8);
        step(1, 1, 3'd0, 8'h00, 2'd0, 4'd0, "v00c");
        chk("v00 second", int'(if2.tmds), int'(10'b1111111111));
        chk("v00 second disp", int'($signed(if2.disparity)), 2);

        // 3: control codes (mode 5..7 alias to control)
        for (int i = 0; i < 4; i++) step(1, 1, 3'd0, 8'h00, 2'(i), 4'd0, "ctrl");
        for (int i = 5; i < 8; i++) step(1, 1, 3'(i), 8'h55, 2'(i), 4'd0, "ctrl_alias");

        // 4: guard bands
        step(1, 1, 3'd2, 8'h00, 2'd0, 4'd0, "vguard");
        for (int i = 0; i < 4; i++) step(1, 1, 3'd3, 8'h00, 2'(i), 4'd0, "dguard");
        step(1, 1, 3'd0, 8'h00, 2'd0, 4'd0, "flush");
        step(1, 1, 3'd0, 8'h00, 2'd0, 4'd0, "flush");

        // 5: TERC4 after video with non-zero disparity, then video restarts from 0
        step(1, 1, 3'd1, 8'h00, 2'd0, 4'd0, "pre_v");
        step(1, 1, 3'd1, 8'h03, 2'd0, 4'd0, "pre_v");
        for (int i = 0; i < 16; i++) step(1, 1, 3'd4, 8'h00, 2'd0, 4'(i), "terc4");
        step(1, 1, 3'd1, 8'h00, 2'd0, 4'd0, "post_v");
        step(1, 1, 3'd1, 8'hA5, 2'd0, 4'd0, "post_v");
        step(1, 1, 3'd1, 8'h3C, 2'd0, 4'd0, "post_v");

        // 6: ce low mid video stream
        for (int i = 0; i < 4; i++) step(1, 1, 3'd1, 8'(8'h10 + i * 37), 2'd0, 4'd0, "v_run");
        for (int i = 0; i < 4; i++) step(1, 0, 3'd1, 8'($urandom), 2'd0, 4'd0, "ce_low");
        for (int i = 0; i < 4; i++) step(1, 1, 3'd1, 8'(8'hE1 + i * 11), 2'd0, 4'd0, "v_resume");

        // reset mid stream discards both stages
        step(0, 0, 3'd1, 8'h77, 2'd0, 4'd0, "rst_mid");
        step(1, 1, 3'd1, 8'h81, 2'd0, 4'd0, "after_rst");
        step(1, 1, 3'd1, 8'h18, 2'd0, 4'd0, "after_rst");

        // random mixed traffic
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                 8'($urandom), 2'($urandom), 4'($urandom), "rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
